// File: rtl/hpu_pkg.sv
// Shared constants and FSM state type for the hypervector bundling datapath.
package hpu_pkg;

    localparam int unsigned DefDim     = 1024;
    localparam int unsigned DefStreamW = 256;
    localparam int unsigned DefAccW    = 27;
    localparam int unsigned DefCoreNum = 14;

    typedef enum logic {
        StIdle,
        StDrain
    } drain_state_e;

endpackage

// File: rtl/majority_counter.sv
// One dimension's signed vote accumulator; sign_o is 1 when the vote is strictly positive.
// BUNDLE_SAT_EN selects clamping instead of two's-complement wrap.
module majority_counter #(
    parameter int unsigned CORENUM = 14,
    parameter int unsigned W       = 27
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [CORENUM-1:0] bits_i,
    input  logic [CORENUM-1:0] store_i,
    input  logic               acc_v_i,
    input  logic               clear_i,
    output logic               sign_o
);

    localparam int unsigned CW = $clog2(CORENUM + 1);

    logic [W-1:0]  acc_q, acc_d, acc_upd;
    logic [CW-1:0] pos_cnt, neg_cnt;

    always_comb begin
        pos_cnt = '0;
        neg_cnt = '0;
        for (int c = 0; c < CORENUM; c++) begin
            pos_cnt = pos_cnt + CW'(store_i[c] & bits_i[c]);
            neg_cnt = neg_cnt + CW'(store_i[c] & ~bits_i[c]);
        end
    end

`ifdef BUNDLE_SAT_EN
    // Wide enough that acc +/- CORENUM never overflows before clamping.
    localparam int unsigned SW = W + CW + 1;
    localparam logic signed [SW-1:0] AccMax = SW'((64'd1 << (W - 1)) - 64'd1);
    localparam logic signed [SW-1:0] AccMin = ~AccMax;

    logic signed [SW-1:0] acc_ext, sum;

    always_comb begin
        acc_ext = {{(SW - W){acc_q[W-1]}}, acc_q};
        sum     = acc_ext + $signed(SW'(pos_cnt)) - $signed(SW'(neg_cnt));
        acc_upd = sum[W-1:0];
        if (sum > AccMax) begin
            acc_upd = AccMax[W-1:0];
        end else if (sum < AccMin) begin
            acc_upd = AccMin[W-1:0];
        end
    end
`else
    always_comb begin
        acc_upd = acc_q + W'(pos_cnt) - W'(neg_cnt);
    end
`endif

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (acc_v_i) begin
            acc_d = acc_upd;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign sign_o = ~acc_q[W-1] & (|acc_q);

endmodule

// File: rtl/bundle_stream_ctrl.sv
// Bundles core result hypervectors into per-dimension majority counters and streams a
// snapshot of the sign vector out in STREAM_W beats. BUNDLE_SAT_EN enables saturation.
module bundle_stream_ctrl
    import hpu_pkg::*;
#(
    parameter int unsigned DIM      = DefDim,
    parameter int unsigned CORENUM  = DefCoreNum,
    parameter int unsigned W        = DefAccW,
    parameter int unsigned STREAM_W = DefStreamW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CORENUM*DIM-1:0] core_result,
    input  logic [CORENUM-1:0]     store,
    input  logic                   acc_v,
    input  logic                   clear,
    input  logic                   start,
    output logic [STREAM_W-1:0]    m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic [DIM-1:0]         sign_bit
);

    localparam int unsigned BEATS = DIM / STREAM_W;
    localparam int unsigned IdxW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BEATS - 1);

    for (genvar j = 0; j < DIM; j++) begin : g_dim
        logic [CORENUM-1:0] dim_bits;
        for (genvar c = 0; c < CORENUM; c++) begin : g_core
            assign dim_bits[c] = core_result[c*DIM + j];
        end

        majority_counter #(
            .CORENUM (CORENUM),
            .W       (W)
        ) u_cnt (
            .clk_i   (clk),
            .rst_i   (rst),
            .bits_i  (dim_bits),
            .store_i (store),
            .acc_v_i (acc_v),
            .clear_i (clear),
            .sign_o  (sign_bit[j])
        );
    end

    drain_state_e                     state_q, state_d;
    logic [BEATS-1:0][STREAM_W-1:0]   snap_q, snap_d;
    logic [IdxW-1:0]                  beat_q, beat_d;
    logic                             last_beat;

    assign last_beat = (beat_q == LastIdx);

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDrain;
                    snap_d  = sign_bit;
                    beat_d  = '0;
                end
            end
            StDrain: begin
                if (m_ready) begin
                    if (last_beat) begin
                        state_d = StIdle;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            snap_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            beat_q  <= beat_d;
        end
    end

    // Outputs decode straight from state so reset clears them without waiting for an edge.
    always_comb begin
        m_valid = (state_q == StDrain);
        busy    = m_valid;
        m_last  = m_valid & last_beat;
        m_data  = m_valid ? snap_q[beat_q] : '0;
    end

endmodule

// File: tb/tb_bundle_stream_ctrl.sv
// Directed bench for bundle_stream_ctrl: accumulate vector table plus drain/reset sequences.
module tb_bundle_stream_ctrl;

    localparam int unsigned DIM  = 1024;
    localparam int unsigned CN   = 14;
    localparam int unsigned SW   = 256;
    localparam int unsigned DIM2 = 256;

    logic             clk = 1'b0;
    logic             rst;

    logic [CN*DIM-1:0] core_result;
    logic [CN-1:0]     store;
    logic              acc_v, clear, start, m_ready;
    logic [SW-1:0]     m_data;
    logic              m_valid, m_last, busy;
    logic [DIM-1:0]    sign_bit;

    logic [CN*DIM2-1:0] core_result2;
    logic [CN-1:0]      store2;
    logic               acc_v2, clear2, start2, m_ready2;
    logic [SW-1:0]      m_data2;
    logic               m_valid2, m_last2, busy2;
    logic [DIM2-1:0]    sign_bit2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bundle_stream_ctrl #(
        .DIM (DIM), .CORENUM (CN), .W (27), .STREAM_W (SW)
    ) u_dut (
        .clk (clk), .rst (rst), .core_result (core_result), .store (store),
        .acc_v (acc_v), .clear (clear), .start (start), .m_data (m_data),
        .m_valid (m_valid), .m_ready (m_ready), .m_last (m_last), .busy (busy),
        .sign_bit (sign_bit)
    );

    bundle_stream_ctrl #(
        .DIM (DIM2), .CORENUM (CN), .W (4), .STREAM_W (SW)
    ) u_dut_w4 (
        .clk (clk), .rst (rst), .core_result (core_result2), .store (store2),
        .acc_v (acc_v2), .clear (clear2), .start (start2), .m_data (m_data2),
        .m_valid (m_valid2), .m_ready (m_ready2), .m_last (m_last2), .busy (busy2),
        .sign_bit (sign_bit2)
    );

    typedef struct {
        logic [CN-1:0] st;
        logic [CN-1:0] pat;
        int            n;
        logic          ev;
        logic          od;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DIM-1:0] act,
                         input logic [DIM-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cores(input logic [DIM-1:0] v);
        for (int c = 0; c < CN; c++) core_result[c*DIM +: DIM] = v;
    endtask

    task automatic set_cores2(input logic [DIM2-1:0] v);
        for (int c = 0; c < CN; c++) core_result2[c*DIM2 +: DIM2] = v;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [DIM-1:0]  ref_v, alt_v, exp_v;
    logic [DIM2-1:0] exp2;
    logic [31:0]     w;

    initial begin
        rst = 1'b1;
        core_result = '0; store = '0; acc_v = 1'b0; clear = 1'b0; start = 1'b0;
        m_ready = 1'b0;
        core_result2 = '0; store2 = '0; acc_v2 = 1'b0; clear2 = 1'b0; start2 = 1'b0;
        m_ready2 = 1'b0;

        tbl[0] = '{14'h3FFF, 14'h01FF, 1, 1'b1, 1'b0};
        tbl[1] = '{14'h0001, 14'h0000, 3, 1'b0, 1'b1};
        tbl[2] = '{14'h3FFF, 14'h007F, 1, 1'b0, 1'b0};
        tbl[3] = '{14'h0000, 14'h3FFF, 2, 1'b0, 1'b0};
        tbl[4] = '{14'h0003, 14'h0001, 2, 1'b0, 1'b0};
        tbl[5] = '{14'h3001, 14'h3000, 1, 1'b1, 1'b0};
        tbl[6] = '{14'h2AAA, 14'h3FFF, 2, 1'b1, 1'b0};
        tbl[7] = '{14'h3FFF, 14'h0000, 1, 1'b0, 1'b1};

        for (int k = 0; k < 4; k++) begin
            w = 32'h1234_5670 + k * 32'h1111_1111;
            ref_v[k*SW +: SW] = {8{w}};
        end
        alt_v = {512{2'b10}};

        // Reset state
        tick();
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_data", m_data, '0);
        check("rst_sign", sign_bit, '0);
        rst = 1'b0;
        tick();

        // Accumulate table: even dims follow pat, odd dims get its complement
        for (int i = 0; i < 8; i++) begin
            do_clear();
            store = tbl[i].st;
            for (int c = 0; c < CN; c++)
                core_result[c*DIM +: DIM] = tbl[i].pat[c] ? {512{2'b01}} : {512{2'b10}};
            acc_v = 1'b1;
            repeat (tbl[i].n) tick();
            acc_v = 1'b0;
            exp_v = {512{{tbl[i].od, tbl[i].ev}}};
            check($sformatf("tbl%0d_sign", i), sign_bit, exp_v);
        end

        // Single core voting zero three times leaves -3 everywhere
        do_clear();
        store = 14'h0001;
        set_cores('0);
        acc_v = 1'b1;
        repeat (3) tick();
        check("neg3_sign", sign_bit, '0);
        set_cores('1);
        repeat (3) tick();
        check("back_to_zero_sign", sign_bit, '0);
        tick();
        acc_v = 1'b0;
        check("plus1_sign", sign_bit, '1);

        // clear wins over a simultaneous sample
        store = '1;
        set_cores('1);
        clear = 1'b1;
        acc_v = 1'b1;
        tick();
        clear = 1'b0;
        acc_v = 1'b0;
        check("clear_wins_sign", sign_bit, '0);
        store = 14'h0001;
        set_cores('0);
        acc_v = 1'b1;
        tick();
        acc_v = 1'b0;
        check("after_clear_neg1", sign_bit, '0);
        set_cores('1);
        acc_v = 1'b1;
        repeat (2) tick();
        acc_v = 1'b0;
        check("after_clear_pos1", sign_bit, '1);

        // Full-speed drain of alternating pattern; a start mid-burst is ignored
        do_clear();
        store = '1;
        set_cores(alt_v);
        acc_v = 1'b1;
        tick();
        acc_v = 1'b0;
        check("alt_sign", sign_bit, alt_v);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("alt_valid%0d", k), m_valid, 1'b1);
            check($sformatf("alt_busy%0d", k), busy, 1'b1);
            check($sformatf("alt_data%0d", k), m_data, alt_v[k*SW +: SW]);
            check($sformatf("alt_last%0d", k), m_last, (k == 3) ? 1'b1 : 1'b0);
            start = (k == 1);
            tick();
        end
        start = 1'b0;
        check("alt_busy_after", busy, 1'b0);
        check("alt_valid_after", m_valid, 1'b0);
        m_ready = 1'b0;

        // Backpressure on beat 1 while accumulators keep moving
        do_clear();
        set_cores(ref_v);
        acc_v = 1'b1;
        tick();
        acc_v = 1'b0;
        check("ref_sign", sign_bit, ref_v);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_ready = 1'b1;
        check("bp_data0", m_data, ref_v[0 +: SW]);
        tick();
        m_ready = 1'b0;
        set_cores(~ref_v);
        acc_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold_data%0d", i), m_data, ref_v[SW +: SW]);
            check($sformatf("bp_hold_valid%0d", i), m_valid, 1'b1);
            check($sformatf("bp_hold_last%0d", i), m_last, 1'b0);
            tick();
        end
        acc_v = 1'b0;
        check("bp_live_sign", sign_bit, ~ref_v);
        m_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            check($sformatf("bp_data%0d", k), m_data, ref_v[k*SW +: SW]);
            check($sformatf("bp_last%0d", k), m_last, (k == 3) ? 1'b1 : 1'b0);
            tick();
        end
        check("bp_busy_after", busy, 1'b0);
        m_ready = 1'b0;

        // Narrow accumulator: clamp vs wrap
        clear2 = 1'b1;
        tick();
        clear2 = 1'b0;
        store2 = '1;
        set_cores2('1);
        acc_v2 = 1'b1;
        tick();
        acc_v2 = 1'b0;
`ifdef BUNDLE_SAT_EN
        exp2 = '1;
`else
        exp2 = '0;
`endif
        check("w4_first", sign_bit2, exp2);
        acc_v2 = 1'b1;
        tick();
        acc_v2 = 1'b0;
        check("w4_second", sign_bit2, exp2);
        store2 = 14'h007F;
        set_cores2('0);
        acc_v2 = 1'b1;
        tick();
        acc_v2 = 1'b0;
`ifdef BUNDLE_SAT_EN
        exp2 = '0;
`else
        exp2 = '1;
`endif
        check("w4_minus7", sign_bit2, exp2);

        // Single-beat drain
        clear2 = 1'b1;
        tick();
        clear2 = 1'b0;
        store2 = 14'h0001;
        set_cores2({128{2'b01}});
        acc_v2 = 1'b1;
        tick();
        acc_v2 = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("b1_valid", m_valid2, 1'b1);
        check("b1_last", m_last2, 1'b1);
        check("b1_data", m_data2, {128{2'b01}});
        m_ready2 = 1'b1;
        tick();
        m_ready2 = 1'b0;
        check("b1_busy_after", busy2, 1'b0);

        // Asynchronous reset in the middle of beat 2
        do_clear();
        store = '1;
        set_cores(ref_v);
        acc_v = 1'b1;
        tick();
        acc_v = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_ready = 1'b1;
        repeat (2) tick();
        check("pre_rst_data2", m_data, ref_v[2*SW +: SW]);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", m_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_last", m_last, 1'b0);
        check("arst_data", m_data, '0);
        check("arst_sign", sign_bit, '0);
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b0;
        acc_v = 1'b1;
        tick();
        acc_v = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_valid", m_valid, 1'b1);
        check("rerun_data0", m_data, ref_v[0 +: SW]);
        check("rerun_last0", m_last, 1'b0);
        m_ready = 1'b1;
        repeat (4) tick();
        check("rerun_busy_after", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
